instr_fetch_unit: RTL

Sequences the word-addressed, combinational-read instruction memory (1024 x 32, read by address >> 2). It holds the fetch PC and drives the memory address. It buffers fetched {pc, instruction} pairs in a small queue and presents them to decode over a valid/ready handshake. It also handles branch/jump redirects and stops fetching on a misaligned or out-of-range fetch address.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/instr_fetch_unit_if.sv | 47 ++++
 rtl/fetch_queue.sv | 76 +++++++
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types, constants and helpers for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  localparam logic [1:0]  CAUSE_NONE     = 2'b00;
  localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0]  CAUSE_RANGE    = 2'b10;
  localparam logic [31:0] WORD_BYTES     = 32'd4;

  // Word index compare, so the top of the 32-bit space never aliases into memory.
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] mem_words);
    return (addr >> 2) < mem_words;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory, redirect, decode handshake and fault signals of the fetch unit.
interface instr_fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_pc;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output if_pc_plus4,
    output fault,
    output fault_cause,
    output fault_pc
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  if_pc_plus4,
    input  fault,
    input  fault_cause,
    input  fault_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, instr} fetch entries; flush wins over push, head reads as 0 when empty.
module fetch_queue #(
  parameter int QDEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [63:0]                   push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [63:0]                   head_data,
  output logic [$clog2(QDEPTH+1)-1:0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  logic [63:0]      entries_q [QDEPTH];
  logic [63:0]      entries_d [QDEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    entries_d = entries_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    do_pop    = pop && (count_q != '0);
    // At full, a same-cycle pop frees the slot the push overwrites.
    do_push   = push && ((count_q != CNT_W'(QDEPTH)) || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        entries_d[wr_ptr_q] = push_data;
        wr_ptr_d            = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        entries_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      entries_q <= entries_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(QDEPTH));
  assign count     = count_q;
  assign head_data = empty ? '0 : entries_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC sequencing, redirect handling and sticky fault capture in front of the fetch queue.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          QDEPTH    = 2
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int               CNT_W       = $clog2(QDEPTH + 1);
  localparam logic [31:0]      MEM_WORDS_U = 32'(MEM_WORDS);
  localparam logic [CNT_W-1:0] QDEPTH_C    = CNT_W'(QDEPTH);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             fault_q, fault_d;
  logic [1:0]       fault_cause_q, fault_cause_d;
  logic [31:0]      fault_pc_q, fault_pc_d;

  logic             pop, push, flush, fetch_in_range;
  logic [63:0]      q_head;
  logic [CNT_W-1:0] q_count;
  logic             q_empty;
  logic             unused_q_full;

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    fault_d        = fault_q;
    fault_cause_d  = fault_cause_q;
    fault_pc_d     = fault_pc_q;
    pop            = bus.if_ready && !q_empty;
    fetch_in_range = addr_in_range(fetch_pc_q, MEM_WORDS_U);
    flush          = (state_q == FETCH) && bus.redirect_valid;
    push           = (state_q == FETCH) && !bus.redirect_valid && fetch_in_range &&
                     ((q_count < QDEPTH_C) || pop);
    if (state_q == FETCH) begin
      if (bus.redirect_valid) begin
        if (bus.redirect_pc[1:0] != 2'b00) begin
          state_d       = FAULT;
          fault_d       = 1'b1;
          fault_cause_d = CAUSE_MISALIGN;
          fault_pc_d    = bus.redirect_pc;
        end else if (!addr_in_range(bus.redirect_pc, MEM_WORDS_U)) begin
          state_d       = FAULT;
          fault_d       = 1'b1;
          fault_cause_d = CAUSE_RANGE;
          fault_pc_d    = bus.redirect_pc;
        end else begin
          fetch_pc_d = bus.redirect_pc;
        end
      end else if (!fetch_in_range) begin
        state_d       = FAULT;
        fault_d       = 1'b1;
        fault_cause_d = CAUSE_RANGE;
        fault_pc_d    = fetch_pc_q;
      end else if (push) begin
        fetch_pc_d = fetch_pc_q + WORD_BYTES;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      fault_q       <= 1'b0;
      fault_cause_q <= CAUSE_NONE;
      fault_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({fetch_pc_q, bus.imem_rdata}),
    .pop       (pop),
    .flush     (flush),
    .head_data (q_head),
    .count     (q_count),
    .full      (unused_q_full),
    .empty     (q_empty)
  );

  assign bus.imem_addr   = fetch_pc_q;
  assign bus.if_valid    = !q_empty;
  assign bus.if_pc       = q_head[63:32];
  assign bus.if_instr    = q_head[31:0];
  assign bus.if_pc_plus4 = q_empty ? '0 : q_head[63:32] + WORD_BYTES;
  assign bus.fault       = fault_q;
  assign bus.fault_cause = fault_cause_q;
  assign bus.fault_pc    = fault_pc_q;

endmodule
